// File: rtl/fetch_pkg.sv
// Shared constants and IF/ID slot type for the fetch stage.
package fetch_pkg;
  localparam logic [31:0] PC_INCR   = 32'd4;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
  localparam logic [31:0] RESET_PC  = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pcplus4;
    logic        valid;
  } ifid_t;

  localparam ifid_t IFID_EMPTY = '{instr: NOP_INSTR, pcplus4: 32'h0, valid: 1'b0};
endpackage

// File: rtl/if_id_register.sv
// IF/ID pipeline register; priority reset > flush > load > hold.
module if_id_register
  import fetch_pkg::*;
(
  input  logic  Clk,
  input  logic  Reset,
  input  logic  Load,
  input  logic  Flush,
  input  ifid_t d,
  output ifid_t q
);
  always_ff @(posedge Clk) begin
    if (Reset)      q <= IFID_EMPTY;
    else if (Flush) q <= IFID_EMPTY;
    else if (Load)  q <= d;
  end
endmodule

// File: rtl/fetch_stage.sv
// Fetch stage: next-PC select, PC write enable and IF/ID control.
// Define DELAY_SLOT_EN for MIPS branch-delay-slot semantics with a pending redirect.
module fetch_stage
  import fetch_pkg::*;
(
  input  logic        Clk,
  input  logic        Reset,
  input  logic [31:0] PCResult,
  input  logic [31:0] Instruction,
  input  logic        Stall,
  input  logic        BranchTaken,
  input  logic [31:0] BranchTarget,
  input  logic        Jump,
  input  logic [31:0] JumpTarget,
  output logic [31:0] Address,
  output logic        PCWrite,
  output logic [31:0] IFID_Instruction,
  output logic [31:0] IFID_PCPlus4,
  output logic        IFID_Valid
);
  logic [31:0] pc_plus4;
  logic        load, flush;
  ifid_t       ifid_d, ifid_q;

  assign pc_plus4 = PCResult + PC_INCR;

`ifdef DELAY_SLOT_EN
  logic        pend;
  logic [31:0] pend_target;

  always_comb begin
    if (BranchTaken) Address = BranchTarget;
    else if (pend)   Address = pend_target;
    else if (Jump)   Address = JumpTarget;
    else             Address = pc_plus4;
  end

  // A redirect seen under stall is parked until the stall lifts.
  assign PCWrite = ~Stall;
  assign load    = ~Stall;
  assign flush   = 1'b0;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      pend        <= 1'b0;
      pend_target <= RESET_PC;
    end else if (!Stall) begin
      pend <= 1'b0;
    end else if (BranchTaken) begin
      pend        <= 1'b1;
      pend_target <= BranchTarget;
    end else if (Jump && !pend) begin
      pend        <= 1'b1;
      pend_target <= JumpTarget;
    end
  end
`else
  logic redirect;

  assign redirect = BranchTaken | Jump;

  always_comb begin
    if (BranchTaken) Address = BranchTarget;
    else if (Jump)   Address = JumpTarget;
    else             Address = pc_plus4;
  end

  // Redirect wins over stall: the wrong-path slot is squashed and PC moves.
  assign PCWrite = ~Stall | redirect;
  assign load    = ~Stall;
  assign flush   = redirect;
`endif

  assign ifid_d = '{instr: Instruction, pcplus4: pc_plus4, valid: 1'b1};

  if_id_register u_ifid (
    .Clk   (Clk),
    .Reset (Reset),
    .Load  (load),
    .Flush (flush),
    .d     (ifid_d),
    .q     (ifid_q)
  );

  assign IFID_Instruction = ifid_q.instr;
  assign IFID_PCPlus4     = ifid_q.pcplus4;
  assign IFID_Valid       = ifid_q.valid;
endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed literal cases plus random traffic vs a model.
module tb_fetch_stage;
  logic        Clk = 1'b0;
  logic        Reset, Stall, BranchTaken, Jump;
  logic [31:0] PCResult, Instruction, BranchTarget, JumpTarget;
  logic [31:0] Address, IFID_Instruction, IFID_PCPlus4;
  logic        PCWrite, IFID_Valid;

  int total = 0;
  int bad   = 0;

  // model state
  logic        model_ok = 1'b0;
  logic [31:0] m_instr, m_pc4, m_ptgt;
  logic        m_valid, m_pend;

  always #5 Clk = ~Clk;

  fetch_stage dut (
    .Clk(Clk), .Reset(Reset), .PCResult(PCResult), .Instruction(Instruction),
    .Stall(Stall), .BranchTaken(BranchTaken), .BranchTarget(BranchTarget),
    .Jump(Jump), .JumpTarget(JumpTarget), .Address(Address), .PCWrite(PCWrite),
    .IFID_Instruction(IFID_Instruction), .IFID_PCPlus4(IFID_PCPlus4),
    .IFID_Valid(IFID_Valid)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

`ifdef DELAY_SLOT_EN
  localparam bit DS = 1'b1;
`else
  localparam bit DS = 1'b0;
`endif

  // Expected combinational outputs from the current inputs and model state.
  function automatic logic [31:0] exp_addr();
    if (BranchTaken)     return BranchTarget;
    if (DS && m_pend)    return m_ptgt;
    if (Jump)            return JumpTarget;
    return PCResult + 32'd4;
  endfunction

  function automatic logic exp_pcw();
    if (DS) return !Stall;
    return !Stall || BranchTaken || Jump;
  endfunction

  // Model update at each rising edge.
  always @(posedge Clk) begin
    if (Reset) begin
      model_ok = 1'b1;
      m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0; m_pend = 1'b0; m_ptgt = 32'h0;
    end else if (!DS && (BranchTaken || Jump)) begin
      m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
    end else if (!Stall) begin
      m_instr = Instruction; m_pc4 = PCResult + 32'd4; m_valid = 1'b1;
      m_pend = 1'b0;
    end else if (DS && BranchTaken) begin
      m_pend = 1'b1; m_ptgt = BranchTarget;
    end else if (DS && Jump && !m_pend) begin
      m_pend = 1'b1; m_ptgt = JumpTarget;
    end
  end

  // Compare process: every falling edge once the model is known.
  always @(negedge Clk) begin
    if (model_ok) begin
      check("cmp_address", Address, exp_addr());
      check("cmp_pcwrite", {31'b0, PCWrite}, {31'b0, exp_pcw()});
      check("cmp_ifid_instr", IFID_Instruction, m_instr);
      check("cmp_ifid_pc4", IFID_PCPlus4, m_pc4);
      check("cmp_ifid_valid", {31'b0, IFID_Valid}, {31'b0, m_valid});
    end
  end

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic idle();
    Stall = 0; BranchTaken = 0; Jump = 0; Reset = 0;
  endtask

  initial begin
    logic [31:0] r;
    Reset = 1; Stall = 0; BranchTaken = 0; Jump = 0;
    PCResult = 0; Instruction = 0; BranchTarget = 0; JumpTarget = 0;
    step(); step();
    check("rst_valid", {31'b0, IFID_Valid}, 32'd0);
    check("rst_instr", IFID_Instruction, 32'h0);
    check("rst_pc4", IFID_PCPlus4, 32'h0);

    // first fetch after reset
    idle(); PCResult = 32'h0; Instruction = 32'h2008_0005;
    @(negedge Clk);
    check("first_addr", Address, 32'h4);
    check("first_pcw", {31'b0, PCWrite}, 32'd1);
    step();
    check("first_instr", IFID_Instruction, 32'h2008_0005);
    check("first_pc4", IFID_PCPlus4, 32'h4);
    check("first_valid", {31'b0, IFID_Valid}, 32'd1);

    // three-cycle stall at 0x10
    PCResult = 32'hC; Instruction = 32'hAAAA_0001;
    step();
    PCResult = 32'h10; Instruction = 32'hBBBB_0002; Stall = 1;
    repeat (3) begin
      @(negedge Clk);
      check("stall_pcw", {31'b0, PCWrite}, 32'd0);
      step();
      check("stall_instr", IFID_Instruction, 32'hAAAA_0001);
      check("stall_pc4", IFID_PCPlus4, 32'h10);
    end
    Stall = 0;
    @(negedge Clk);
    check("resume_addr", Address, 32'h14);
    step();
    check("resume_instr", IFID_Instruction, 32'hBBBB_0002);
    check("resume_pc4", IFID_PCPlus4, 32'h14);

    // branch and jump in the same cycle
    PCResult = 32'h14; Instruction = 32'hCCCC_0003;
    BranchTaken = 1; BranchTarget = 32'h40; Jump = 1; JumpTarget = 32'h80;
    @(negedge Clk);
    check("bj_addr", Address, 32'h40);
    step();
    check("bj_valid", {31'b0, IFID_Valid}, DS ? 32'd1 : 32'd0);
    check("bj_instr", IFID_Instruction, DS ? 32'hCCCC_0003 : 32'h0);
    idle();

    // PC wrap
    PCResult = 32'hFFFF_FFFC; Instruction = 32'h1234_5678;
    @(negedge Clk);
    check("wrap_addr", Address, 32'h0);
    step();
    check("wrap_pc4", IFID_PCPlus4, 32'h0);

    // branch under stall
    PCResult = 32'h20; Stall = 1; BranchTaken = 1; BranchTarget = 32'h100;
    @(negedge Clk);
    check("bst_pcw", {31'b0, PCWrite}, DS ? 32'd0 : 32'd1);
    if (!DS) check("bst_addr", Address, 32'h100);
    step();
    BranchTaken = 0;
    check("bst_valid", {31'b0, IFID_Valid}, DS ? 32'd1 : 32'd0);
    @(negedge Clk);
    check("bst_hold_pcw", {31'b0, PCWrite}, 32'd0);
    step();
    Stall = 0;
    @(negedge Clk);
    check("bst_release_addr", Address, DS ? 32'h100 : 32'h24);
    check("bst_release_pcw", {31'b0, PCWrite}, 32'd1);
    step();
    @(negedge Clk);
    check("bst_cleared_addr", Address, 32'h24);

    // reset while a redirect is parked
    Stall = 1; BranchTaken = 1; BranchTarget = 32'h200;
    step();
    BranchTaken = 0; Reset = 1;
    step();
    check("rstp_valid", {31'b0, IFID_Valid}, 32'd0);
    idle(); PCResult = 32'h0;
    @(negedge Clk);
    check("rstp_addr", Address, 32'h4);
    step();

    // random traffic, model compared every cycle
    for (int i = 0; i < 3000; i++) begin
      Reset       = ($urandom_range(0, 99) < 2);
      Stall       = ($urandom_range(0, 99) < 35);
      BranchTaken = ($urandom_range(0, 99) < 15);
      Jump        = ($urandom_range(0, 99) < 15);
      r = $urandom;
      PCResult    = ($urandom_range(0, 19) == 0) ? 32'hFFFF_FFFC : (r & 32'hFFFF_FFFC);
      Instruction = $urandom;
      r = $urandom; BranchTarget = r & 32'hFFFF_FFFC;
      r = $urandom; JumpTarget   = r & 32'hFFFF_FFFC;
      step();
    end
    idle();
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL provide one clock and one reset; reset is synchronous and active-high.
REQ-002 Clk  in  1  clock; all state updates on rising edge.
REQ-003 Reset  in  1  synchronous active-high reset.
REQ-004 PCResult  in  32  current PC from program counter register.
REQ-005 Instruction  in  32  instruction memory read data for PCResult (combinational).
REQ-006 Stall  in  1  hazard-unit stall request; holds PC and IF/ID.
REQ-007 BranchTaken  in  1  EX-stage resolved taken branch.
REQ-008 BranchTarget  in  32  branch target address.
REQ-009 Jump  in  1  ID-stage decoded jump.
REQ-010 JumpTarget  in  32  jump target address.
REQ-011 Address  out  32  next PC to program counter Address input.
REQ-012 PCWrite  out  1  PC write enable to program counter.
REQ-013 IFID_Instruction  out  32  registered instruction to decode.
REQ-014 IFID_PCPlus4  out  32  registered PCResult+4.
REQ-015 IFID_Valid  out  1  registered slot holds a real instruction.

Function
REQ-016 PCPlus4 = PCResult + 4, modulo 2^32; 0xFFFFFFFC wraps to 0x00000000.
REQ-017 Next-PC priority: BranchTaken > pending redirect > Jump > PCPlus4; Address driven combinationally.
REQ-018 BranchTaken and Jump same cycle: Address = BranchTarget; Jump ignored (younger instruction).
REQ-019 PCWrite = 1 unless Stall=1 and no redirect is taking effect that cycle.
REQ-020 Normal cycle (no Stall, no redirect): IF/ID loads Instruction, PCPlus4, Valid=1; latency one cycle from fetch to decode.
REQ-021 Stall=1, no redirect: IF/ID holds all fields unchanged; PCWrite=0.
REQ-022 Redirect (BranchTaken or Jump) without DELAY_SLOT_EN: IF/ID loads Instruction=0x00000000, PCPlus4=0, Valid=0 (flush), overriding Stall.
REQ-023 Redirect with DELAY_SLOT_EN: see Configuration.
REQ-024 Flushed slot SHALL be 0x00000000 (sll $0,$0,0 NOP).
REQ-025 IFID_Instruction/IFID_PCPlus4/IFID_Valid change only on rising Clk.

Reset
REQ-026 Reset=1 at clock edge: IFID_Instruction=0, IFID_PCPlus4=0, IFID_Valid=0, pending redirect cleared; overrides Stall and redirects.
REQ-027 Reset mid-operation discards any pending redirect; first post-reset fetch is address 0x00000000 (PC reset).
REQ-028 Address and PCWrite remain combinational during Reset (PC register ignores them).

Configuration
REQ-029 Macro DELAY_SLOT_EN selects MIPS branch-delay-slot semantics.
REQ-030 Defined: redirect does not flush; IF/ID loads delay-slot instruction with Valid=1 when Stall=0.
REQ-031 Defined, redirect while Stall=1: target latched into 32-bit pending register plus pending flag; PCWrite=0; IF/ID holds; on first Stall=0 cycle Address = pending target, PCWrite=1, flag clears.
REQ-032 Defined, new BranchTaken while pending: overwrites pending target.
REQ-033 Not defined: pending register and flag absent; REQ-022 applies.

Structure
REQ-034 Shared package fetch_pkg: PC_INCR=4, NOP_INSTR=32'h00000000, RESET_PC=32'h00000000.
REQ-035 Sub-module if_id_register: holds Instruction/PCPlus4/Valid with load, hold, flush controls; fetch_stage contains next-PC mux and control.

Verification
REQ-036 Reset 2 cycles, PCResult=0, Instruction=0x20080005 -> after next edge IFID_Instruction=0x20080005, IFID_PCPlus4=4, IFID_Valid=1; Address=4, PCWrite=1.
REQ-037 Stall=1 for 3 cycles at PCResult=0x10 -> PCWrite=0, IF/ID unchanged all 3 cycles; resumes loading at 0x14.
REQ-038 BranchTaken=1, BranchTarget=0x40, Jump=1, JumpTarget=0x80 same cycle -> Address=0x40; without DELAY_SLOT_EN IFID_Valid=0, IFID_Instruction=0.
REQ-039 BranchTaken=1 with Stall=1 -> no macro: PCWrite=1, Address=target, flush; DELAY_SLOT_EN: PCWrite=0, when Stall drops Address=target, PCWrite=1.
REQ-040 PCResult=0xFFFFFFFC, no redirect -> Address=0x00000000, IFID_PCPlus4=0x00000000.
REQ-041 Reset asserted while pending redirect (DELAY_SLOT_EN) -> pending cleared, IFID_Valid=0, next fetch from 0x00000000.
